cmd_fetch_buf: RTL and testbench



---
 rtl/cmd_fetch_buf.sv | 212 +++++++++++++++++++++
 tb/tb_cmd_fetch_buf.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fetch_buf.sv
// Prefetching command fetch unit: credit-limited reads to MEM_TO_CMD banks, epoch-tagged latency pipe,
// head-registered command FIFO. Define CMD_FETCH_STATS_EN to add the stat_fetched/stat_discarded counters.
module cmd_fetch_buf #(
  parameter int unsigned CMD_ADDR_WIDTH   = 8,
  parameter int unsigned MEM_WIDTH        = 32,
  parameter int unsigned MEM_TO_CMD       = 4,
  parameter int unsigned MEM_READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [CMD_ADDR_WIDTH-1:0]           start_addr,
  input  logic                                stop,
  input  logic                                jump_valid,
  input  logic [CMD_ADDR_WIDTH-1:0]           jump_addr,
  output logic                                mem_en,
  output logic [CMD_ADDR_WIDTH-1:0]           mem_addr,
  input  logic [MEM_WIDTH*MEM_TO_CMD-1:0]     mem_rdata,
  output logic [MEM_WIDTH*MEM_TO_CMD-1:0]     cmd_out,
  output logic [CMD_ADDR_WIDTH-1:0]           cmd_addr,
  output logic                                cmd_valid,
  input  logic                                cmd_ready,
  output logic                                busy
`ifdef CMD_FETCH_STATS_EN
  ,
  output logic [31:0]                         stat_fetched,
  output logic [15:0]                         stat_discarded
`endif
);

  localparam int unsigned CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
  localparam int          LAT       = int'(MEM_READ_LATENCY);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + MEM_READ_LATENCY + 2) + 1;

  typedef logic [CMD_ADDR_WIDTH-1:0] addr_t;
  typedef logic [CMD_WIDTH-1:0]      cmd_t;
  typedef enum logic {ST_IDLE, ST_FETCH} state_e;

  state_e           state_q, state_d;
  addr_t            fetch_ptr_q, fetch_ptr_d;
  logic             epoch_q, epoch_d;
  logic             mem_en_q, mem_en_d;
  addr_t            mem_addr_q, mem_addr_d;
  logic [LAT-1:0]   pipe_vld_q, pipe_vld_d;
  logic [LAT-1:0]   pipe_epoch_q, pipe_epoch_d;
  addr_t            pipe_addr_q [LAT];
  addr_t            pipe_addr_d [LAT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cmd_t             cmd_out_q, cmd_out_d;
  addr_t            cmd_addr_q, cmd_addr_d;
  logic             cmd_valid_q, cmd_valid_d;

  cmd_t             fifo_data_mem [FIFO_DEPTH];
  addr_t            fifo_addr_mem [FIFO_DEPTH];

  logic             in_fetch, redirect, pop, push, issue;
  logic [OCC_W-1:0] inflight;
  addr_t            redirect_addr;

  // Reads in flight: the one on the bank interface now plus every valid pipe stage.
  always_comb begin
    inflight = OCC_W'(mem_en_q);
    for (int i = 0; i < LAT; i++) inflight = inflight + OCC_W'(pipe_vld_q[i]);
  end

  assign in_fetch      = (state_q == ST_FETCH);
  assign redirect      = in_fetch && (stop || jump_valid || start);
  assign redirect_addr = jump_valid ? jump_addr : start_addr;
  assign pop           = cmd_valid_q && cmd_ready && !redirect;
  assign push          = pipe_vld_q[LAT-1] && (pipe_epoch_q[LAT-1] == epoch_q) && !redirect;
  // A same-cycle pop frees its slot, which is what sustains one command per cycle.
  assign issue         = in_fetch && !redirect &&
                         ((inflight + OCC_W'(count_q) - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    epoch_d     = epoch_q;
    if (in_fetch) begin
      if (stop) begin
        state_d = ST_IDLE;
        epoch_d = ~epoch_q;
      end else if (jump_valid || start) begin
        fetch_ptr_d = redirect_addr;
        epoch_d     = ~epoch_q;
      end else if (issue) begin
        fetch_ptr_d = fetch_ptr_q + CMD_ADDR_WIDTH'(1);
      end
    end else if (start) begin
      state_d     = ST_FETCH;
      fetch_ptr_d = start_addr;
    end

    mem_en_d   = issue;
    mem_addr_d = issue ? fetch_ptr_q : mem_addr_q;

    // Redirect clears every in-flight valid bit, so back-to-back redirects cannot alias on the 1-bit epoch.
    pipe_vld_d[0]   = mem_en_q && !redirect;
    pipe_epoch_d[0] = epoch_q;
    pipe_addr_d[0]  = mem_addr_q;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i]   = pipe_vld_q[i-1] && !redirect;
      pipe_epoch_d[i] = pipe_epoch_q[i-1];
      pipe_addr_d[i]  = pipe_addr_q[i-1];
    end

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Head register: bypass the incoming return when it lands in the slot that becomes the head.
    cmd_valid_d = (count_d != '0);
    cmd_out_d   = cmd_out_q;
    cmd_addr_d  = cmd_addr_q;
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      cmd_out_d  = mem_rdata;
      cmd_addr_d = pipe_addr_q[LAT-1];
    end else if (count_d != '0) begin
      cmd_out_d  = fifo_data_mem[rd_ptr_d];
      cmd_addr_d = fifo_addr_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_ptr_q  <= '0;
      epoch_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      pipe_vld_q   <= '0;
      pipe_epoch_q <= '0;
      for (int i = 0; i < LAT; i++) pipe_addr_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_out_q    <= '0;
      cmd_addr_q   <= '0;
      cmd_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_ptr_q  <= fetch_ptr_d;
      epoch_q      <= epoch_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_epoch_q <= pipe_epoch_d;
      pipe_addr_q  <= pipe_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_out_q    <= cmd_out_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_valid_q  <= cmd_valid_d;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= mem_rdata;
      fifo_addr_mem[wr_ptr_q] <= pipe_addr_q[LAT-1];
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign cmd_out   = cmd_out_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign busy      = in_fetch || (inflight != '0);

`ifdef CMD_FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [15:0] stat_discarded_q, stat_discarded_d;
  logic [16:0] disc_sum;

  // A redirect drops everything in flight plus everything buffered.
  always_comb begin
    stat_fetched_d = stat_fetched_q;
    if (push && (stat_fetched_q != '1)) stat_fetched_d = stat_fetched_q + 32'd1;
    disc_sum         = {1'b0, stat_discarded_q} +
                       (redirect ? 17'(inflight + OCC_W'(count_q)) : 17'd0);
    stat_discarded_d = disc_sum[16] ? '1 : disc_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_d;
      stat_discarded_q <= stat_discarded_d;
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_discarded = stat_discarded_q;
`endif

endmodule

// File: tb/tb_cmd_fetch_buf.sv
// Directed bench for cmd_fetch_buf: fixed-latency bank model, delivery/issue monitors, one task per scenario.
module tb_cmd_fetch_buf;
  localparam int AW = 8, MW = 32, NB = 4, LAT = 2, DEPTH = 4, CW = MW * NB;

  logic          clk = 1'b0;
  logic          reset, start, stop, jump_valid, cmd_ready;
  logic [AW-1:0] start_addr, jump_addr;
  logic          mem_en, cmd_valid, busy;
  logic [AW-1:0] mem_addr, cmd_addr;
  logic [CW-1:0] mem_rdata, cmd_out;
`ifdef CMD_FETCH_STATS_EN
  logic [31:0]   stat_fetched;
  logic [15:0]   stat_discarded;
`endif

  int n_checks = 0, n_pass = 0, cyc = 0;

  cmd_fetch_buf #(.CMD_ADDR_WIDTH(AW), .MEM_WIDTH(MW), .MEM_TO_CMD(NB),
                  .MEM_READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cmd_out(cmd_out), .cmd_addr(cmd_addr), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy)
`ifdef CMD_FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_discarded(stat_discarded)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word i of address a is {8'hC0, a, i}.
  function automatic logic [CW-1:0] exp_cmd(input logic [AW-1:0] a);
    logic [CW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*MW +: MW] = {8'hC0, a, 16'(i)};
    return r;
  endfunction

  // Bank model: samples mem_en/mem_addr at an edge, data valid LAT edges after the issue edge.
  logic [1:0]    m_vld = 2'b00;
  logic [AW-1:0] m_addr0 = '0, m_addr1 = '0;
  always @(posedge clk) begin
    m_vld   <= {m_vld[0], mem_en};
    m_addr0 <= mem_addr;
    m_addr1 <= m_addr0;
  end
  assign mem_rdata = m_vld[1] ? exp_cmd(m_addr1) : {NB{32'hDEAD_BEEF}};

  logic [AW-1:0] got_addr[$];
  logic [CW-1:0] got_data[$];
  int            got_cyc[$];
  logic [AW-1:0] iss_addr[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        got_addr.push_back(cmd_addr);
        got_data.push_back(cmd_out);
        got_cyc.push_back(cyc);
      end
      if (mem_en === 1'b1) iss_addr.push_back(mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_addr.delete(); got_data.delete(); got_cyc.delete(); iss_addr.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; jump_valid = 1'b0; cmd_ready = 1'b0;
    start_addr = '0; jump_addr = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    start = 1'b1; start_addr = a;
    tick();
    start = 1'b0;
  endtask

  // First delivered command has address base, and nothing outside [base, base+15] is delivered.
  task automatic check_stream(input string name, input logic [AW-1:0] base);
    int bad = 0;
    n_checks++;
    if (got_addr.size() == 0) $display("FAIL %s_first: got no command, expected addr %h", name, base);
    else if (got_addr[0] !== base || got_data[0] !== exp_cmd(base))
      $display("FAIL %s_first: got addr %h data %h, expected addr %h data %h",
               name, got_addr[0], got_data[0], base, exp_cmd(base));
    else n_pass++;
    foreach (got_addr[k])
      if ((got_addr[k] - base) > 8'd15 || got_data[k] !== exp_cmd(got_addr[k])) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL %s_stale: got %0d bad commands, expected 0", name, bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b expected 0", mem_en); else n_pass++;
    n_checks++; if (mem_addr !== '0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rst_cmd_valid: got %b expected 0", cmd_valid); else n_pass++;
    n_checks++; if (cmd_out !== '0) $display("FAIL rst_cmd_out: got %h expected 0", cmd_out); else n_pass++;
    n_checks++; if (cmd_addr !== '0) $display("FAIL rst_cmd_addr: got %h expected 0", cmd_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
`ifdef CMD_FETCH_STATS_EN
    n_checks++; if (stat_fetched !== '0) $display("FAIL rst_stat_fetched: got %0d expected 0", stat_fetched); else n_pass++;
    n_checks++; if (stat_discarded !== '0) $display("FAIL rst_stat_discarded: got %0d expected 0", stat_discarded); else n_pass++;
`endif
  endtask

  task automatic test_basic_fetch();
    int first_en = -1, first_v = -1;
    do_reset();
    cmd_ready = 1'b1;
    clear_mon();
    pulse_start(8'h10);
    for (int i = 0; i < 20; i++) begin
      if (mem_en === 1'b1 && first_en < 0) first_en = cyc;
      if (cmd_valid === 1'b1 && first_v < 0) first_v = cyc;
      tick();
    end
    n_checks++;
    if (first_en < 0 || first_v - first_en != LAT + 1)
      $display("FAIL basic_latency: got %0d cycles (en at %0d), expected %0d", first_v - first_en, first_en, LAT + 1);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (k >= got_addr.size()) $display("FAIL basic_cmd%0d: got nothing, expected addr %h", k, 8'h10 + k);
      else if (got_addr[k] !== 8'(8'h10 + k) || got_data[k] !== exp_cmd(8'(8'h10 + k)) || got_cyc[k] != got_cyc[0] + k)
        $display("FAIL basic_cmd%0d: got addr %h data %h cyc +%0d, expected addr %h data %h cyc +%0d",
                 k, got_addr[k], got_data[k], got_cyc[k] - got_cyc[0], 8'h10 + k, exp_cmd(8'(8'h10 + k)), k);
      else n_pass++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL stop_idle: got busy %b valid %b mem_en %b, expected 0 0 0", busy, cmd_valid, mem_en);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    clear_mon();
    pulse_start(8'h10);
    repeat (15) tick();
    n_checks++;
    if (iss_addr.size() != DEPTH) $display("FAIL bp_issue_count: got %0d expected %0d", iss_addr.size(), DEPTH);
    else n_pass++;
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 8'h10 || cmd_out !== exp_cmd(8'h10))
      $display("FAIL bp_head: got valid %b addr %h data %h, expected 1 10 %h", cmd_valid, cmd_addr, cmd_out, exp_cmd(8'h10));
    else n_pass++;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    cmd_ready = 1'b1;
    repeat (12) tick();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (k >= got_addr.size()) $display("FAIL bp_drain%0d: got nothing, expected addr %h", k, 8'h10 + k);
      else if (got_addr[k] !== 8'(8'h10 + k) || got_cyc[k] != got_cyc[0] + k)
        $display("FAIL bp_drain%0d: got addr %h cyc +%0d, expected addr %h cyc +%0d",
                 k, got_addr[k], got_cyc[k] - got_cyc[0], 8'h10 + k, k);
      else n_pass++;
    end
    n_checks++;
    if (iss_addr.size() <= DEPTH) $display("FAIL bp_resume: got %0d issues, expected more than %0d", iss_addr.size(), DEPTH);
    else if (iss_addr[DEPTH] !== 8'h14) $display("FAIL bp_resume: got addr %h expected 14", iss_addr[DEPTH]);
    else n_pass++;
  endtask

  task automatic test_jump_flush();
`ifdef CMD_FETCH_STATS_EN
    logic [15:0] disc0;
`endif
    do_reset();
    clear_mon();
    pulse_start(8'h10);
    repeat (5) tick();   // 4 issued: 2 buffered, 2 still in the latency pipe
    n_checks++;
    if (cmd_valid !== 1'b1 || iss_addr.size() != 4)
      $display("FAIL jump_setup: got valid %b issues %0d, expected 1 4", cmd_valid, iss_addr.size());
    else n_pass++;
`ifdef CMD_FETCH_STATS_EN
    disc0 = stat_discarded;
`endif
    jump_valid = 1'b1; jump_addr = 8'h80;
    tick();
    jump_valid = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL jump_flush: got valid %b mem_en %b busy %b, expected 0 0 1", cmd_valid, mem_en, busy);
    else n_pass++;
`ifdef CMD_FETCH_STATS_EN
    n_checks++;
    if (stat_discarded - disc0 !== 16'd4) $display("FAIL jump_discarded: got +%0d expected +4", stat_discarded - disc0);
    else n_pass++;
`endif
    cmd_ready = 1'b1;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    tick();
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h80)
      $display("FAIL jump_resume: got mem_en %b addr %h, expected 1 80", mem_en, mem_addr);
    else n_pass++;
    repeat (12) tick();
    check_stream("jump", 8'h80);
  endtask

  task automatic test_wrap();
    do_reset();
    cmd_ready = 1'b1;
    clear_mon();
    pulse_start(8'hFE);
    repeat (12) tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= got_addr.size()) $display("FAIL wrap%0d: got nothing, expected addr %h", k, 8'(8'hFE + k));
      else if (got_addr[k] !== 8'(8'hFE + k) || got_data[k] !== exp_cmd(8'(8'hFE + k)))
        $display("FAIL wrap%0d: got addr %h data %h, expected addr %h", k, got_addr[k], got_data[k], 8'(8'hFE + k));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n20 = 0;
    do_reset();
    cmd_ready = 1'b1;
    pulse_start(8'h10);
    repeat (6) tick();
    jump_valid = 1'b1; jump_addr = 8'h20;
    tick();
    clear_mon();
    jump_addr = 8'h40;
    tick();
    jump_valid = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) $display("FAIL b2b_flush: got valid %b expected 0", cmd_valid); else n_pass++;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    repeat (12) tick();
    check_stream("b2b", 8'h40);
    foreach (iss_addr[k]) if (iss_addr[k] == 8'h20) n20++;
    n_checks++;
    if (iss_addr.size() == 0 || iss_addr[0] !== 8'h40 || n20 != 0)
      $display("FAIL b2b_issue: got %0d issues of 20, first issue %h, expected 0 and 40",
               n20, iss_addr.size() ? iss_addr[0] : 8'h00);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    pulse_start(8'h30);
    repeat (8) tick();
    n_checks++;
    if (cmd_valid !== 1'b1 || busy !== 1'b1) $display("FAIL mrst_full: got valid %b busy %b, expected 1 1", cmd_valid, busy);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL mrst_clear: got valid %b mem_en %b busy %b, expected 0 0 0", cmd_valid, mem_en, busy);
    else n_pass++;
    cmd_ready = 1'b1;
    clear_mon();
    pulse_start(8'h50);
    repeat (12) tick();
    check_stream("mrst_full", 8'h50);
    // Reset with reads still in the pipe, restart immediately.
    cmd_ready = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    pulse_start(8'h60);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd_ready = 1'b1;
    clear_mon();
    pulse_start(8'h70);
    repeat (12) tick();
    check_stream("mrst_inflight", 8'h70);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_jump_flush();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
